// File: rtl/spi_master_driver.sv
// SPI master: one byte per transfer, MSB first, all four CPOL/CPHA modes,
// with programmable sclk divider and chip-select setup/hold times.
module spi_master_driver #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic [1:0] mode,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt;
    logic [3:0] edge_cnt;
    logic       cpha_q;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;
    logic [7:0] rx_q;
    logic       sclk_q;
    logic       mosi_q;
    logic       done_q;

    logic setup_end;
    logic tick;
    logic last_edge;
    logic hold_end;

    always_comb begin
        setup_end = (state == SETUP) && (cnt == SETUP_LAST);
        tick      = (state == XFER)  && (cnt == DIV_LAST);
        last_edge = tick && (edge_cnt == 4'd15);
        hold_end  = (state == HOLD)  && (cnt == HOLD_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = SETUP;
            SETUP:   if (setup_end) state_nxt = XFER;
            XFER:    if (last_edge) state_nxt = HOLD;
            HOLD:    if (hold_end)  state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        cs_n    = (state == IDLE);
        // Idle clock polarity tracks the live mode input, but reset wins.
        sclk    = (state == IDLE) ? (mode[1] & ~rst) : sclk_q;
        mosi    = mosi_q;
        done    = done_q;
        rx_data = rx_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            edge_cnt <= '0;
            cpha_q   <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_q     <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    edge_cnt <= '0;
                    if (start) begin
                        tx_sh  <= tx_data;
                        rx_sh  <= '0;
                        cpha_q <= mode[0];
                        sclk_q <= mode[1];
                        if (!mode[0]) mosi_q <= tx_data[7];
                    end
                end
                SETUP: begin
                    cnt <= setup_end ? '0 : cnt + 8'd1;
                end
                XFER: begin
                    cnt <= tick ? '0 : cnt + 8'd1;
                    if (tick) begin
                        sclk_q   <= ~sclk_q;
                        edge_cnt <= last_edge ? '0 : edge_cnt + 4'd1;
                        // Even edge_cnt is a leading edge; CPHA picks which edge samples.
                        if (edge_cnt[0] == cpha_q) begin
                            rx_sh <= {rx_sh[6:0], miso};
                        end else if (cpha_q || (edge_cnt != 4'd15)) begin
                            mosi_q <= cpha_q ? tx_sh[7] : tx_sh[6];
                            tx_sh  <= {tx_sh[6:0], 1'b0};
                        end
                    end
                end
                HOLD: begin
                    cnt <= hold_end ? '0 : cnt + 8'd1;
                    if (hold_end) begin
                        done_q <= 1'b1;
                        rx_q   <= rx_sh;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_driver.sv
// Directed bench for spi_master_driver: a default-parameter instance and a
// fast instance, each with a behavioural SPI slave sampled on the falling clk.
module tb_spi_master_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [7:0] tx_data;
    logic [1:0] mode;

    logic       busy_w [2];
    logic       done_w [2];
    logic [7:0] rx_w   [2];
    logic       sclk_w [2];
    logic       mosi_w [2];
    logic       miso_w [2] = '{1'b0, 1'b0};
    logic       cs_w   [2];

    logic [1:0] s_mode;
    logic [7:0] s_tx;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spi_master_driver #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .tx_data(tx_data), .mode(mode),
        .busy(busy_w[0]), .done(done_w[0]), .rx_data(rx_w[0]), .sclk(sclk_w[0]),
        .mosi(mosi_w[0]), .miso(miso_w[0]), .cs_n(cs_w[0])
    );

    spi_master_driver #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .tx_data(tx_data), .mode(mode),
        .busy(busy_w[1]), .done(done_w[1]), .rx_data(rx_w[1]), .sclk(sclk_w[1]),
        .mosi(mosi_w[1]), .miso(miso_w[1]), .cs_n(cs_w[1])
    );

    // Slave and line monitor state, one slot per instance.
    int         low_run[2]   = '{0, 0};
    int         high_run[2]  = '{0, 0};
    int         last_low[2]  = '{0, 0};
    int         last_high[2] = '{0, 0};
    int         s_edges[2]   = '{0, 0};
    int         s_bit[2]     = '{0, 0};
    int         rise_cnt[2]  = '{0, 0};
    int         period[2]    = '{0, 0};
    int         done_cnt[2]  = '{0, 0};
    int         rx_bad[2]    = '{0, 0};
    logic [7:0] s_rx[2]      = '{8'h00, 8'h00};
    logic [7:0] prev_rx[2]   = '{8'h00, 8'h00};
    logic       prev_cs[2]   = '{1'b1, 1'b1};
    logic       prev_sclk[2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        logic lead;
        for (int g = 0; g < 2; g++) begin
            if (done_w[g]) done_cnt[g]++;
            if (!done_w[g] && !rst && (rx_w[g] !== prev_rx[g])) rx_bad[g]++;
            prev_rx[g] = rx_w[g];
            if (cs_w[g]) begin
                if (!prev_cs[g]) begin
                    last_low[g] = low_run[g];
                    high_run[g] = 1;
                end else begin
                    high_run[g]++;
                end
            end else if (prev_cs[g]) begin
                last_high[g] = high_run[g];
                low_run[g]   = 1;
                s_rx[g]      = 8'h00;
                s_edges[g]   = 0;
                s_bit[g]     = 0;
                rise_cnt[g]  = 0;
                if (!s_mode[0]) miso_w[g] = s_tx[7];
            end else begin
                low_run[g]++;
                rise_cnt[g]++;
                if (sclk_w[g] !== prev_sclk[g]) begin
                    s_edges[g]++;
                    lead = (sclk_w[g] !== s_mode[1]);
                    if (lead == !s_mode[0]) begin
                        s_rx[g] = {s_rx[g][6:0], mosi_w[g]};
                    end else if (s_mode[0]) begin
                        miso_w[g] = s_tx[7 - s_bit[g]];
                        s_bit[g]++;
                    end else if (s_bit[g] < 7) begin
                        s_bit[g]++;
                        miso_w[g] = s_tx[7 - s_bit[g]];
                    end
                    if (sclk_w[g] && !prev_sclk[g]) begin
                        period[g]   = rise_cnt[g];
                        rise_cnt[g] = 0;
                    end
                end
            end
            prev_cs[g]   = cs_w[g];
            prev_sclk[g] = sclk_w[g];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_xfer(input int d, input logic [1:0] m, input logic [7:0] tx, input logic [7:0] sb);
        @(negedge clk);
        mode    = m;
        tx_data = tx;
        s_mode  = m;
        s_tx    = sb;
        if (d == 0) start_a = 1'b1;
        else        start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int d, input string tag);
        int n = 0;
        while (done_w[d] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, {31'd0, done_w[d]}, 32'd1);
    endtask

    initial begin
        logic [1:0] m;
        int         d0;

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        tx_data = 8'h00; mode = 2'b00; s_mode = 2'b00; s_tx = 8'h00;
        repeat (2) @(negedge clk);
        mode = 2'b11;
        #1;
        check("rst_cs_n",  {31'd0, cs_w[0]},   32'd1);
        check("rst_sclk",  {31'd0, sclk_w[0]}, 32'd0);
        check("rst_mosi",  {31'd0, mosi_w[0]}, 32'd0);
        check("rst_busy",  {31'd0, busy_w[0]}, 32'd0);
        check("rst_done",  {31'd0, done_w[0]}, 32'd0);
        check("rst_rx",    {24'd0, rx_w[0]},   32'h00);
        rst = 1'b0;
        #1;
        check("idle_sclk_follows_mode", {31'd0, sclk_w[0]}, 32'd1);
        mode = 2'b00;

        // Mode 0 basic transfer
        do_xfer(0, 2'b00, 8'hA5, 8'h3C);
        check("m0_setup_cs_n", {31'd0, cs_w[0]}, 32'd0);
        wait_done(0, "m0");
        check("m0_rx",       {24'd0, rx_w[0]},   32'h3C);
        check("m0_done_cs",  {31'd0, cs_w[0]},   32'd1);
        check("m0_done_bsy", {31'd0, busy_w[0]}, 32'd0);
        @(negedge clk);
        check("m0_done_1cyc", {31'd0, done_w[0]}, 32'd0);
        @(negedge clk);
        check("m0_mosi_bits", {24'd0, s_rx[0]}, 32'hA5);
        check("m0_cs_low",    last_low[0],       32'd68);
        check("m0_edges",     s_edges[0],        32'd16);

        // Modes 1..3
        for (int i = 1; i < 4; i++) begin
            m = 2'(i);
            @(negedge clk);
            mode = m;
            #1;
            check($sformatf("m%0d_idle_pol", i), {31'd0, sclk_w[0]}, {31'd0, m[1]});
            do_xfer(0, m, 8'h96, 8'h69);
            check($sformatf("m%0d_setup_pol", i), {31'd0, sclk_w[0]}, {31'd0, m[1]});
            wait_done(0, $sformatf("m%0d", i));
            check($sformatf("m%0d_rx", i), {24'd0, rx_w[0]}, 32'h69);
            repeat (2) @(negedge clk);
            check($sformatf("m%0d_mosi", i),  {24'd0, s_rx[0]}, 32'h96);
            check($sformatf("m%0d_edges", i), s_edges[0],       32'd16);
            check($sformatf("m%0d_cs_low", i), last_low[0],     32'd68);
        end

        // Start spam and input changes mid-transfer
        d0 = done_cnt[0];
        do_xfer(0, 2'b01, 8'h5A, 8'hC3);
        repeat (40) begin
            @(negedge clk);
            start_a = 1'b1;
            tx_data = 8'($urandom);
            mode    = 2'b10;
        end
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0, "spam");
        check("spam_rx",        {24'd0, rx_w[0]},   32'hC3);
        check("spam_live_sclk", {31'd0, sclk_w[0]}, 32'd1);
        repeat (3) @(negedge clk);
        check("spam_mosi",   {24'd0, s_rx[0]},   32'h5A);
        check("spam_edges",  s_edges[0],         32'd16);
        check("spam_cs_low", last_low[0],        32'd68);
        check("spam_ndone",  done_cnt[0] - d0,   32'd1);
        check("spam_idle",   {31'd0, busy_w[0]}, 32'd0);
        mode = 2'b00;

        // Back-to-back via start in the done cycle
        d0 = done_cnt[0];
        do_xfer(0, 2'b00, 8'hFF, 8'h81);
        wait_done(0, "b2b1");
        check("b2b1_rx",   {24'd0, rx_w[0]}, 32'h81);
        check("b2b1_mosi", {24'd0, s_rx[0]}, 32'hFF);
        start_a = 1'b1;
        tx_data = 8'h00;
        s_tx    = 8'h7E;
        @(negedge clk);
        start_a = 1'b0;
        check("b2b2_cs_n", {31'd0, cs_w[0]}, 32'd0);
        wait_done(0, "b2b2");
        check("b2b2_rx", {24'd0, rx_w[0]}, 32'h7E);
        repeat (2) @(negedge clk);
        check("b2b2_mosi",  {24'd0, s_rx[0]}, 32'h00);
        check("b2b_cs_gap", last_high[0],     32'd1);
        check("b2b_ndone",  done_cnt[0] - d0, 32'd2);

        // Reset during the 5th bit
        d0 = done_cnt[0];
        do_xfer(0, 2'b10, 8'h3C, 8'hA5);
        repeat (34) @(negedge clk);
        check("abort_busy_before", {31'd0, busy_w[0]}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_cs_n", {31'd0, cs_w[0]},   32'd1);
        check("abort_busy", {31'd0, busy_w[0]}, 32'd0);
        check("abort_sclk", {31'd0, sclk_w[0]}, 32'd0);
        check("abort_rx",   {24'd0, rx_w[0]},   32'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_sclk_idle", {31'd0, sclk_w[0]}, 32'd1);
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt[0] - d0, 32'd0);
        do_xfer(0, 2'b10, 8'h3C, 8'hA5);
        wait_done(0, "post");
        check("post_rx", {24'd0, rx_w[0]}, 32'hA5);
        repeat (2) @(negedge clk);
        check("post_mosi",   {24'd0, s_rx[0]}, 32'h3C);
        check("post_cs_low", last_low[0],      32'd68);

        // Minimum timing instance, mode 3
        do_xfer(1, 2'b11, 8'hC9, 8'h5E);
        wait_done(1, "fast");
        check("fast_rx", {24'd0, rx_w[1]}, 32'h5E);
        repeat (2) @(negedge clk);
        check("fast_mosi",   {24'd0, s_rx[1]}, 32'hC9);
        check("fast_cs_low", last_low[1],      32'd34);
        check("fast_edges",  s_edges[1],       32'd16);
        check("fast_period", period[1],        32'd4);

        check("a_rx_stable", rx_bad[0], 32'd0);
        check("b_rx_stable", rx_bad[1], 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
